// File: rtl/argmax_pkg.sv
// Shared constants for the argmax / top-K display block: FSM encoding and hex glyphs.
package argmax_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Segment order {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  function automatic logic [6:0] hex_glyph(input logic [3:0] h);
    logic [6:0] g;
    case (h)
      4'h0: g = SEG_0;
      4'h1: g = SEG_1;
      4'h2: g = SEG_2;
      4'h3: g = SEG_3;
      4'h4: g = SEG_4;
      4'h5: g = SEG_5;
      4'h6: g = SEG_6;
      4'h7: g = SEG_7;
      4'h8: g = SEG_8;
      4'h9: g = SEG_9;
      4'hA: g = SEG_A;
      4'hB: g = SEG_B;
      4'hC: g = SEG_C;
      4'hD: g = SEG_D;
      4'hE: g = SEG_E;
      default: g = SEG_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_hex.sv
// Registered hex-digit to 7-segment decoder; shows '0' out of reset.
module seg7_hex
  import argmax_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  logic [6:0] r_seg;

  // Decode and register the glyph
  always_ff @(posedge clk) begin
    if (rst) r_seg <= SEG_0;
    else     r_seg <= hex_glyph(i_hex);
  end

  assign o_seg = r_seg;

endmodule

// File: rtl/argmax_topk_display.sv
// Serial argmax/argmin with a sorted top-K list and a hex display of the winner.
// One score is inserted per cycle from a shadow copy captured at load.
module argmax_topk_display
  import argmax_pkg::*;
#(
  parameter int N_CH = 10,
  parameter int DW   = 16,
  parameter int K    = 3,
  parameter int IW   = (N_CH < 2) ? 1 : $clog2(N_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_CH*DW-1:0] data,
  input  logic               load,
  input  logic               mode,
  output logic               busy,
  output logic               complete,
  output logic [3:0]         index,
  output logic [K*IW-1:0]    topk_idx,
  output logic [K*DW-1:0]    topk_val,
  output logic [K-1:0]       topk_vld,
  output logic [6:0]         display
);

  if (N_CH > 16 || N_CH < 2 || K < 1 || K > N_CH) begin : g_bad_params
    $fatal(1, "argmax_topk_display: illegal N_CH/K combination");
  end

  logic [1:0]                r_state;
  logic [N_CH-1:0][DW-1:0]   r_sh;
  logic                      r_mode;
  logic [IW-1:0]             r_cnt;
  logic [K-1:0][DW-1:0]      r_wval;
  logic [K-1:0][IW-1:0]      r_widx;
  logic [K-1:0]              r_wvld;
  logic [K-1:0][DW-1:0]      r_oval;
  logic [K-1:0][IW-1:0]      r_oidx;
  logic [K-1:0]              r_ovld;
  logic [3:0]                r_index;
  logic                      r_busy;
  logic                      r_complete;

  logic [DW-1:0]             w_x;
  logic [K-1:0][DW-1:0]      w_nval;
  logic [K-1:0][IW-1:0]      w_nidx;
  logic [K-1:0]              w_nvld;
  logic [3:0]                w_index_nxt;

  assign w_x = r_sh[r_cnt];

  // Insertion network: slot r takes the new score if it is the first slot
  // that is empty or beaten; every slot below that point shifts down by one.
  // Strict compare keeps the earlier (lower) channel ahead on ties.
  for (genvar r = 0; r < K; r++) begin : g_slot
    logic w_take;
    logic w_below;
    assign w_take = !r_wvld[r] ||
                    (r_mode ? ($signed(w_x) < $signed(r_wval[r]))
                            : ($signed(w_x) > $signed(r_wval[r])));
    if (r == 0) begin : g_first
      assign w_below   = 1'b0;
      assign w_nval[r] = w_take ? w_x   : r_wval[r];
      assign w_nidx[r] = w_take ? r_cnt : r_widx[r];
      assign w_nvld[r] = w_take | r_wvld[r];
    end else begin : g_rest
      assign w_below   = g_slot[r-1].w_below | g_slot[r-1].w_take;
      assign w_nval[r] = w_below ? r_wval[r-1] : (w_take ? w_x   : r_wval[r]);
      assign w_nidx[r] = w_below ? r_widx[r-1] : (w_take ? r_cnt : r_widx[r]);
      assign w_nvld[r] = w_below ? r_wvld[r-1] : (w_take | r_wvld[r]);
    end
  end

  // Display follows index on the same edge, so decode the next index value
  assign w_index_nxt = (r_state == ST_DONE) ? 4'(r_widx[0]) : r_index;

  // Control FSM, shadow capture, working list and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_sh       <= '0;
      r_mode     <= 1'b0;
      r_cnt      <= '0;
      r_wval     <= '0;
      r_widx     <= '0;
      r_wvld     <= '0;
      r_oval     <= '0;
      r_oidx     <= '0;
      r_ovld     <= '0;
      r_index    <= '0;
      r_busy     <= 1'b0;
      r_complete <= 1'b0;
    end else begin
      r_complete <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (load) begin
            r_sh    <= data;
            r_mode  <= mode;
            r_cnt   <= '0;
            r_wvld  <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          r_wval <= w_nval;
          r_widx <= w_nidx;
          r_wvld <= w_nvld;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == IW'(N_CH - 1)) r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_oval     <= r_wval;
          r_oidx     <= r_widx;
          r_ovld     <= r_wvld;
          r_index    <= 4'(r_widx[0]);
          r_complete <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  seg7_hex u_seg (
    .clk   (clk),
    .rst   (rst),
    .i_hex (w_index_nxt),
    .o_seg (display)
  );

  assign busy     = r_busy;
  assign complete = r_complete;
  assign index    = r_index;
  assign topk_idx = r_oidx;
  assign topk_val = r_oval;
  assign topk_vld = r_ovld;

endmodule
